// File: rtl/dz_countdown.sv
// dz_countdown: one-second countdown sequencer feeding the dot-matrix display.
// Divides clk by TICK_DIV to make a count tick and steps num from START_VAL
// down to 0, with start/restart, pause/resume and a one-cycle done pulse.
// Optional feature macro: DZ_COUNTDOWN_AUTORELOAD_EN -- when defined, DONE
// runs the prescaler for one more tick period and then reloads START_VAL and
// returns to RUN, looping indefinitely. When undefined, DONE holds num at 0
// until start or reset.
module dz_countdown #(
    parameter int TICK_DIV  = 1000,
    parameter int START_VAL = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    output logic [2:0] num,
    output logic       running,
    output logic       done
);

    // Prescaler is ceil(log2(TICK_DIV)) bits; TICK_DIV >= 2 keeps this >= 1.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0]    LOAD_VAL   = 3'(START_VAL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [2:0]    num_nxt;
    logic          running_nxt;
    logic          done_nxt;
    logic          tick;
    logic          last_step;

    // Decrement that saturates at zero so num can never wrap to 7.
    function automatic logic [2:0] sat_dec(input logic [2:0] val);
        if (val == 3'd0) begin
            return 3'd0;
        end
        return val - 3'd1;
    endfunction

    // A tick is only meaningful while counting in RUN.
    assign tick      = (state == RUN) && (presc == PRESC_LAST);
    // The tick that brings num to 0 ends the run (num==0 is treated the same
    // so a corrupted count still terminates instead of underflowing).
    assign last_step = (num <= 3'd1);

    // Next-state, next-count and next-prescaler selection.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        num_nxt   = num;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                // Waiting for start; pause has no meaning here.
            end

            RUN: begin
                // The prescaler advances on every RUN cycle, including the one
                // in which pause is seen, so run time excludes only PAUSE cycles.
                if (tick) begin
                    presc_nxt = '0;
                    num_nxt   = sat_dec(num);
                    if (last_step) begin
                        // Reaching zero wins over a simultaneous pause.
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (pause) begin
                        state_nxt = PAUSE;
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                    if (pause) begin
                        state_nxt = PAUSE;
                    end
                end
            end

            PAUSE: begin
                // Prescaler and num are frozen; resume from where we stopped.
                if (pause) begin
                    state_nxt = RUN;
                end
            end

            DONE: begin
`ifdef DZ_COUNTDOWN_AUTORELOAD_EN
                // Hold 0 for one tick period, then reload and run again.
                if (presc == PRESC_LAST) begin
                    state_nxt = RUN;
                    num_nxt   = LOAD_VAL;
                    presc_nxt = '0;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
`else
                // Hold 0 until start or reset.
`endif
            end

            default: begin
                state_nxt = IDLE;
                num_nxt   = LOAD_VAL;
                presc_nxt = '0;
            end
        endcase

        // start (re)loads the count from any state and beats pause and tick.
        if (start) begin
            state_nxt = RUN;
            num_nxt   = LOAD_VAL;
            presc_nxt = '0;
            done_nxt  = 1'b0;
        end

        running_nxt = (state_nxt == RUN);
    end

    // State, count, prescaler and registered outputs; reset has priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            num     <= LOAD_VAL;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            num     <= num_nxt;
            presc   <= presc_nxt;
            running <= running_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dz_countdown.sv
// Directed bench for dz_countdown with TICK_DIV=4, START_VAL=5.
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
module tb_dz_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [2:0] num;
    logic       running;
    logic       done;

    int errors = 0;
    int checks = 0;

    dz_countdown #(
        .TICK_DIV (4),
        .START_VAL(5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pause  (pause),
        .num    (num),
        .running(running),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_num,
                           input logic e_run, input logic e_done);
        chk({tag, ".num"}, 32'(num), 32'(e_num));
        chk({tag, ".running"}, 32'(running), 32'(e_run));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        pause = 1'b0;

        // Reset for two edges, then idle for 20 cycles with a stray pause.
        cyc();
        cyc();
        chk_all("reset", 3'd5, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            pause = (k == 7);
            cyc();
            chk_all("idle", 3'd5, 1'b0, 1'b0);
        end
        pause = 1'b0;

        // Full count: 5..0 at 4-cycle intervals, done on the 20th edge.
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("run_entry", 3'd5, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk_all("full_count", 3'(5 - k / 4), (k < 20), (k == 20));
        end

`ifdef DZ_COUNTDOWN_AUTORELOAD_EN
        // Four cycles of 0, reload to 5, then another full run with done.
        for (int k = 21; k <= 44; k++) begin
            cyc();
            if (k < 24) chk_all("reload_wait", 3'd0, 1'b0, 1'b0);
            else        chk_all("reload_run", 3'(5 - (k - 24) / 4), (k < 44), (k == 44));
        end
`else
        // DONE holds 0 for 100 cycles; pause is ignored there.
        for (int k = 0; k < 100; k++) begin
            pause = (k == 10);
            cyc();
            chk_all("done_hold", 3'd0, 1'b0, 1'b0);
        end
        pause = 1'b0;
`endif

        // Pause at prescaler=2 with num=4, hold 10 cycles, resume.
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (6) cyc();
        chk_all("pre_pause", 3'd4, 1'b1, 1'b0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk_all("paused", 3'd4, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk_all("pause_hold", 3'd4, 1'b0, 1'b0);
        end
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk_all("resume", 3'd4, 1'b1, 1'b0);
        cyc();
        chk_all("resume_step", 3'd3, 1'b1, 1'b0);

        // start+pause together from IDLE gives RUN.
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk_all("reset_again", 3'd5, 1'b0, 1'b0);
        start = 1'b1;
        pause = 1'b1;
        cyc();
        start = 1'b0;
        pause = 1'b0;
        chk_all("start_beats_pause", 3'd5, 1'b1, 1'b0);

        // Tick with pause at num=3: decrement to 2 and enter PAUSE.
        repeat (11) cyc();
        chk_all("before_tick_pause", 3'd3, 1'b1, 1'b0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk_all("tick_pause", 3'd2, 1'b0, 1'b0);
        repeat (3) cyc();
        chk_all("tick_pause_hold", 3'd2, 1'b0, 1'b0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk_all("tick_pause_resume", 3'd2, 1'b1, 1'b0);
        repeat (3) cyc();
        chk_all("wrapped_presc", 3'd2, 1'b1, 1'b0);
        cyc();
        chk_all("wrapped_step", 3'd1, 1'b1, 1'b0);

        // Tick with pause at num=1: DONE wins over PAUSE.
        repeat (3) cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk_all("done_beats_pause", 3'd0, 1'b0, 1'b1);
        cyc();
        chk_all("done_single", 3'd0, 1'b0, 1'b0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        chk_all("done_pause_ignored", 3'd0, 1'b0, 1'b0);

        // Restart at num=2 reloads 5 with prescaler cleared.
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (13) cyc();
        chk_all("before_restart", 3'd2, 1'b1, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk_all("restart", 3'd5, 1'b1, 1'b0);
        repeat (3) cyc();
        chk_all("restart_presc0", 3'd5, 1'b1, 1'b0);
        cyc();
        chk_all("restart_step", 3'd4, 1'b1, 1'b0);

        // Reset at num=3 returns to IDLE with no trailing done pulse.
        repeat (5) cyc();
        chk_all("before_reset", 3'd3, 1'b1, 1'b0);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk_all("reset_midrun", 3'd5, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            cyc();
            chk_all("post_reset", 3'd5, 1'b0, 1'b0);
        end

        // Reset beats a simultaneous start.
        rst   = 1'b0;
        start = 1'b1;
        cyc();
        rst   = 1'b1;
        start = 1'b0;
        chk_all("reset_beats_start", 3'd5, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
